// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store stage: memory op, FSM state, access size and error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_LD_MISALIGN = 2'd0,
    ERR_ST_MISALIGN = 2'd1,
    ERR_ILLEGAL     = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } err_code_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication, access legality checks, load lane select and extension.
// Purely combinational; request side uses incoming fields, load side uses the latched request.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_store_data,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_illegal,
  output logic            o_misalign,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_lane;

  // funct3[1:0] encodes the size for both signed and unsigned loads
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign o_illegal  = (i_is_load  & ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11))) |
                      (i_is_store & (i_funct3[2] | (i_funct3[1:0] == 2'b11)));
  assign o_misalign = ((i_funct3[1:0] == 2'b01) & i_off[0]) |
                      ((i_funct3[1:0] == 2'b10) & (i_off != 2'b00));

  assign w_lane = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = w_lane;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      F3_H:    o_ld_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory stage: req/gnt/rvalid data-memory access with one registered writeback beat per instruction.
// Non-memory ops and faults beat one cycle after accept; ready_o is low while a memory access is in flight.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      mem_op_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            wb_en_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o,
  output logic [1:0]      err_code_o
);

  localparam logic [15:0] TMO_LAST = 16'(BUS_TIMEOUT - 1);

  lsu_state_e      r_state, w_state_nxt;
  logic [15:0]     r_tmo;
  logic            r_we;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [3:0]      r_be;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [4:0]      r_rd;
  logic            r_wb_vld, r_wb_we, r_err;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_dat;
  logic [1:0]      r_err_code;

  logic            w_accept, w_is_load, w_is_store, w_illegal, w_misalign;
  logic            w_tmo_hit, w_latch, w_tmo_clr;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_ld_data;
  logic            w_wb_vld, w_wb_we, w_err;
  logic [4:0]      w_wb_rd;
  logic [XLEN-1:0] w_wb_dat;
  logic [1:0]      w_err_code;

  assign ready_o    = (r_state == IDLE);
  assign w_accept   = valid_i & ready_o;
  assign w_is_load  = (mem_op_i == MEM_LOAD);
  assign w_is_store = (mem_op_i == MEM_STORE);
  assign w_tmo_hit  = (BUS_TIMEOUT != 0) && (r_tmo == TMO_LAST);

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_is_load    (w_is_load),
    .i_is_store   (w_is_store),
    .i_funct3     (funct3_i),
    .i_off        (alu_result_i[1:0]),
    .i_store_data (store_data_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_illegal    (w_illegal),
    .o_misalign   (w_misalign),
    .i_ld_funct3  (r_funct3),
    .i_ld_off     (r_off),
    .i_rdata      (dmem_rdata_i),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_tmo_clr   = 1'b0;
    w_wb_vld    = 1'b0;
    w_wb_we     = 1'b0;
    w_wb_rd     = r_rd;
    w_wb_dat    = '0;
    w_err       = 1'b0;
    w_err_code  = 2'd0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_wb_rd = rd_addr_i;
        if (!(w_is_load || w_is_store)) begin
          w_wb_vld = 1'b1;
          w_wb_we  = wb_en_i;
          w_wb_dat = alu_result_i;
        end else if (w_illegal || w_misalign) begin
          w_wb_vld   = 1'b1;
          w_err      = 1'b1;
          w_err_code = w_illegal ? ERR_ILLEGAL : (w_is_load ? ERR_LD_MISALIGN : ERR_ST_MISALIGN);
        end else begin
          w_latch     = 1'b1;
          w_tmo_clr   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: if (dmem_gnt_i) begin
        w_tmo_clr = 1'b1;
        if (r_we || dmem_rvalid_i) begin
          w_wb_vld    = 1'b1;
          w_wb_we     = !r_we;
          w_wb_dat    = r_we ? '0 : w_ld_data;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
        end
      end else if (w_tmo_hit) begin
        w_wb_vld    = 1'b1;
        w_err       = 1'b1;
        w_err_code  = ERR_TIMEOUT;
        w_state_nxt = IDLE;
      end
      WAIT: if (dmem_rvalid_i) begin
        w_wb_vld    = 1'b1;
        w_wb_we     = 1'b1;
        w_wb_dat    = w_ld_data;
        w_state_nxt = IDLE;
      end else if (w_tmo_hit) begin
        w_wb_vld    = 1'b1;
        w_err       = 1'b1;
        w_err_code  = ERR_TIMEOUT;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_tmo      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_rd       <= '0;
      r_wb_vld   <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_dat   <= '0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_vld   <= w_wb_vld;
      r_wb_we    <= w_wb_we;
      r_wb_rd    <= w_wb_rd;
      r_wb_dat   <= w_wb_dat;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      if (w_tmo_clr)
        r_tmo <= '0;
      else if (r_state != IDLE)
        r_tmo <= r_tmo + 16'd1;
      if (w_latch) begin
        r_we     <= w_is_store;
        r_addr   <= {alu_result_i[XLEN-1:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_is_store ? w_wdata : '0;
        r_funct3 <= funct3_i;
        r_off    <= alu_result_i[1:0];
        r_rd     <= rd_addr_i;
      end
    end
  end

  assign dmem_req_o   = (r_state == REQ);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign wb_valid_o   = r_wb_vld;
  assign wb_we_o      = r_wb_we;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_dat;
  assign err_o        = r_err;
  assign err_code_o   = r_err_code;

endmodule
